// File: rtl/variable_clk_bank.sv
// ---------------------------------------------------------------------------
// variable_clk_bank
//   Bank of CH programmable square-wave generators for tone/rate generation.
//   A shared prescaler produces a count-enable (ps_tick) every PRESCALE clks;
//   each channel counts ps_ticks and toggles its output every act_div steps,
//   where act_div is a shadow of div_in reloaded only at half-period ends.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   en       [CH]        per-channel enable (0 forces channel low and idle)
//   div_in   [CH*DIV_W]  half-period divisor, channel c at [c*DIV_W +: DIV_W]
//   sync     one-cycle strobe: restarts every channel and the prescaler
//   var_clk  [CH]        divided clocks (registered)
//   tick     [CH]        one-cycle pulse in the first high cycle of var_clk
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// vcb_lane
//   One divider channel.
//
// Ports:
//   clk, rst_n  clock / async active-low reset
//   en          channel enable
//   sync        realign strobe
//   ps_tick     shared count-enable from the prescaler
//   div_in      requested half-period divisor
//   var_clk     divided clock
//   tick        rising-edge pulse, coincident with the first high cycle
// ---------------------------------------------------------------------------
module vcb_lane #(
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             ps_tick,
  input  logic [DIV_W-1:0] div_in,
  output logic             var_clk,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act_div;

  // cnt only ever runs 0..act_div-1, so a full-scale divisor cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      act_div <= '0;
      var_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!en) begin
        cnt     <= '0;
        act_div <= '0;
        var_clk <= 1'b0;
      end else if (sync) begin
        cnt     <= '0;
        act_div <= div_in;
        var_clk <= 1'b0;
      end else if (ps_tick) begin
        if (act_div == '0) begin
          // Idle: sit low and keep sampling div_in until it is nonzero.
          cnt     <= '0;
          act_div <= div_in;
          var_clk <= 1'b0;
        end else if (cnt == act_div - ONE) begin
          // Half-period boundary: the only place a new divisor takes effect.
          cnt     <= '0;
          act_div <= div_in;
          if (div_in == '0) begin
            var_clk <= 1'b0;
          end else begin
            var_clk <= ~var_clk;
            tick    <= ~var_clk;
          end
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule

module variable_clk_bank #(
  parameter int CH       = 4,
  parameter int DIV_W    = 10,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       en,
  input  logic [CH*DIV_W-1:0] div_in,
  input  logic                sync,
  output logic [CH-1:0]       var_clk,
  output logic [CH-1:0]       tick
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic            PS_ONE  = (PRESCALE == 1);

  logic [PS_W-1:0]            ps_cnt;
  logic                       ps_tick;
  logic [CH-1:0][DIV_W-1:0]   div_arr;

  assign div_arr = div_in;

  // Registered count-enable, high one cycle in every PRESCALE. With
  // PRESCALE=1 the counter never leaves 0 and ps_tick stays high after
  // the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt  <= '0;
      ps_tick <= 1'b0;
    end else if (sync) begin
      ps_cnt  <= '0;
      ps_tick <= PS_ONE;
    end else begin
      ps_cnt  <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
      ps_tick <= (ps_cnt == PS_LAST);
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    vcb_lane #(.DIV_W(DIV_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[c]),
      .sync    (sync),
      .ps_tick (ps_tick),
      .div_in  (div_arr[c]),
      .var_clk (var_clk[c]),
      .tick    (tick[c])
    );
  end

endmodule

// File: tb/tb_variable_clk_bank.sv
// Scoreboard bench: stimulus pushes the expected tick cycle numbers per
// channel; a negedge monitor pops and compares whenever a tick appears.
// Index 0..3 = PRESCALE=1 instance, 4..7 = PRESCALE=4 instance.
module tb_variable_clk_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en, en4;
  logic [39:0] div_in, div4;
  logic        sync, sync4;
  logic [3:0]  var_clk, tick, var4, tick4;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[8][$];

  variable_clk_bank #(.CH(4), .DIV_W(10), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in), .sync(sync),
    .var_clk(var_clk), .tick(tick));

  variable_clk_bank #(.CH(4), .DIV_W(10), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .div_in(div4), .sync(sync4),
    .var_clk(var4), .tick(tick4));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick must match the next expected cycle for its channel.
  always @(negedge clk) begin
    logic [7:0] tk;
    int e;
    tk = {tick4, tick};
    for (int i = 0; i < 8; i++) begin
      if (tk[i]) begin
        n_tests++;
        if (exp_q[i].size() == 0) begin
          n_fail++;
          $display("FAIL tick_unexpected idx%0d: tick at cycle %0d, none expected", i, cyc);
        end else begin
          e = exp_q[i].pop_front();
          if (e != cyc) begin
            n_fail++;
            $display("FAIL tick_time idx%0d: tick at cycle %0d, expected %0d", i, cyc, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_timeout: at cycle %0d expected to reach %0d", cyc, n);
    end
  endtask

  task automatic push(input int i, input int cy);
    exp_q[i].push_back(cy);
  endtask

  task automatic set_div(input bit inst, input int c, input int v);
    if (inst) div4[c*10 +: 10] = 10'(v);
    else      div_in[c*10 +: 10] = 10'(v);
  endtask

  initial begin
    int s, s2, s4, r1;
    int dv[4];
    rst_n = 0; en = 0; en4 = 0; div_in = 0; div4 = 0; sync = 0; sync4 = 0;
    repeat (2) @(negedge clk);
    chk("reset_var_clk", var_clk, 0);
    chk("reset_tick", tick, 0);
    chk("reset_var4", var4, 0);
    chk("reset_tick4", tick4, 0);
    rst_n = 1;
    @(negedge clk);

    // Divide-by-200, loaded by sync at edge s.
    en[0] = 1; set_div(0, 0, 200); sync = 1; s = cyc + 1;
    push(0, s + 200); push(0, s + 600);
    @(negedge clk); sync = 0;
    wait_to(s + 199); chk("d200_low_before_rise", var_clk[0], 0);
    wait_to(s + 200); chk("d200_first_rise", var_clk[0], 1);
    wait_to(s + 399); chk("d200_high_end", var_clk[0], 1);
    wait_to(s + 400); chk("d200_fall", var_clk[0], 0);
    wait_to(s + 600); chk("d200_second_rise", var_clk[0], 1);

    // Mid-half-period change to 25 at cnt=50 of the low half starting s+800.
    wait_to(s + 850); set_div(0, 0, 25);
    push(0, s + 1000); push(0, s + 1050); push(0, s + 1100);
    wait_to(s + 999);  chk("chg_old_half_holds", var_clk[0], 0);
    wait_to(s + 1000); chk("chg_rise_at_200", var_clk[0], 1);
    wait_to(s + 1024); chk("chg_high_25", var_clk[0], 1);
    wait_to(s + 1025); chk("chg_fall_25", var_clk[0], 0);
    wait_to(s + 1050); chk("chg_rise_50", var_clk[0], 1);

    // D=0 during a low half: boundary at s+1150 is forced low, then idle.
    wait_to(s + 1130); set_div(0, 0, 0);
    wait_to(s + 1149); chk("d0_low_half", var_clk[0], 0);
    wait_to(s + 1150); chk("d0_forced_low", var_clk[0], 0);
    wait_to(s + 1165); chk("d0_idle_held", var_clk[0], 0);
    wait_to(s + 1170); set_div(0, 0, 3);
    push(0, s + 1174); push(0, s + 1180);
    wait_to(s + 1173); chk("d3_before_rise", var_clk[0], 0);
    wait_to(s + 1174); chk("d3_first_rise", var_clk[0], 1);
    wait_to(s + 1177); chk("d3_fall", var_clk[0], 0);
    wait_to(s + 1182); en[0] = 0;
    @(negedge clk); chk("d3_disabled", var_clk[0], 0);

    // Independence and sync: divisors 1,2,3,5.
    dv[0] = 1; dv[1] = 2; dv[2] = 3; dv[3] = 5;
    en = 4'hF;
    for (int c = 0; c < 4; c++) set_div(0, c, dv[c]);
    sync = 1; s2 = cyc + 1;
    for (int c = 0; c < 4; c++)
      for (int k = dv[c]; k <= 30; k += 2 * dv[c]) push(c, s2 + k);
    @(negedge clk); sync = 0;
    chk("sync_all_low", var_clk, 0);
    wait_to(s2 + 1); chk("sync_ch0_rise", var_clk, 4'b0001);
    wait_to(s2 + 4); chk("sync_pattern4", var_clk, 4'b0100);
    wait_to(s2 + 5); chk("sync_pattern5", var_clk, 4'b1101);
    wait_to(s2 + 30); en = 4'h0;
    @(negedge clk); chk("sync_all_disabled", var_clk, 0);

    // PRESCALE=4, div=2: period 16; sync-load rises 9 edges after sync.
    en4 = 4'b0011; set_div(1, 0, 2); set_div(1, 1, 2);
    sync4 = 1; s4 = cyc + 1;
    push(4, s4 + 9); push(4, s4 + 25); push(4, s4 + 41);
    push(5, s4 + 9);
    @(negedge clk); sync4 = 0;
    wait_to(s4 + 8);  chk("ps4_before_rise", var4, 4'b0000);
    wait_to(s4 + 9);  chk("ps4_rise", var4, 4'b0011);
    wait_to(s4 + 12); en4[1] = 0;
    @(negedge clk); chk("ps4_en1_drop", var4, 4'b0001);
    wait_to(s4 + 17); chk("ps4_fall", var4, 4'b0000);
    wait_to(s4 + 25); chk("ps4_period16", var4, 4'b0001);

    // Async reset mid-cycle while ch0 is high (41..48).
    wait_to(s4 + 44);
    chk("pre_reset_high", var4[0], 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_var4", var4, 0);
    chk("async_reset_tick4", tick4, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1; r1 = cyc + 1;
    // Idle-load at the first ps_tick edge (r1+4), rise 2 ps_ticks later.
    push(4, r1 + 12); push(4, r1 + 28);
    wait_to(r1 + 11); chk("rst_restart_low", var4[0], 0);
    wait_to(r1 + 12); chk("rst_restart_rise", var4[0], 1);
    wait_to(r1 + 20); chk("rst_restart_fall", var4[0], 0);
    wait_to(r1 + 28); chk("rst_restart_rise2", var4[0], 1);
    wait_to(r1 + 30);

    for (int i = 0; i < 8; i++) chk($sformatf("ticks_missing_idx%0d", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
